nios_system_pio_in_irq: RTL and testbench
=========================================

NIOS_SYSTEM_PIO_IN_IRQ -- requirements
Module: nios_system_pio_in_irq

Interface
REQ-001 Parameter WIDTH, default 8: input port width, legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: number of synchronizer flops on in_port, legal range 2..4.
REQ-003 Parameter EDGE_TYPE, default 0: edge that sets a capture bit. 0 = rising, 1 = falling, 2 = any.
REQ-004 Parameter BIT_CLEAR, default 1: 1 = write-1-to-clear per bit on edge capture; 0 = any write to edge capture clears all bits.
REQ-005 clk  input  1: system clock; all state on posedge clk.
REQ-006 reset_n  input  1: reset, asynchronous, active-low.
REQ-007 address  input  2: Avalon-MM word address.
REQ-008 chipselect  input  1: slave select; qualifies writes only.
REQ-009 write_n  input  1: active-low write strobe.
REQ-010 writedata  input  32: write data.
REQ-011 in_port  input  WIDTH: asynchronous external inputs.
REQ-012 readdata  output  32: registered read data.
REQ-013 irq  output  1: level interrupt request, active-high.

Function
REQ-014 in_port SHALL pass through a SYNC_STAGES-deep flop chain; sync_q is the last stage; prev_q is sync_q delayed one clk.
REQ-015 Register map (word address): 0 = data (RO, sync_q); 1 = reserved (reads 0, writes ignored); 2 = irq_mask (RW, WIDTH bits); 3 = edge_capture (RO plus clear semantics).
REQ-016 Bits [31:WIDTH] of every read SHALL be 0; writedata bits [31:WIDTH] SHALL be ignored.
REQ-017 A write occurs on a clk edge where chipselect=1 and write_n=0; register update is visible on the following cycle.
REQ-018 readdata SHALL be registered every clk, regardless of chipselect: readdata(n+1) = mux(address(n)); read latency is 1 cycle.
REQ-019 Edge detect per bit: rising = sync_q & ~prev_q; falling = ~sync_q & prev_q; any = sync_q ^ prev_q, per EDGE_TYPE.
REQ-020 A detected edge SHALL set edge_capture[i] on the same clk edge on which the edge is detected; edge_capture[i] stays set until cleared.
REQ-021 Clearing with BIT_CLEAR=1: a write to address 3 clears edge_capture[i] where writedata[i]=1; other bits are unchanged.
REQ-022 Clearing with BIT_CLEAR=0: a write to address 3 clears all bits, regardless of writedata.
REQ-023 When a clear and a new edge on bit i happen on the same clk, the set SHALL win and edge_capture[i]=1.
REQ-024 Edges are captured whatever the irq_mask value; the mask gates irq only.
REQ-025 irq SHALL equal the registered OR-reduction of (edge_capture & irq_mask), updated one clk after either operand changes.
REQ-026 Total latency from an in_port transition (meeting setup) to irq assertion SHALL be SYNC_STAGES+2 clk.
REQ-027 A read of address 3 SHALL NOT clear edge_capture.
REQ-028 A pulse on in_port shorter than one clk period is not guaranteed to be captured.

Reset
REQ-029 On reset_n=0, independent of clk: sync chain, prev_q, irq_mask, edge_capture and readdata SHALL clear to 0, and irq SHALL be 0.
REQ-030 If in_port is 1 at reset release with EDGE_TYPE=0, the 0-to-1 transition seen after reset SHALL be captured as a rising edge.
REQ-031 Assertion of reset mid-operation SHALL discard pending captures and the mask immediately; no irq glitch high is permitted.
REQ-032 Synchronous deassertion of reset_n is the integrator's responsibility.

Verification
REQ-033 Setup WIDTH=8, SYNC_STAGES=2, in_port=8'hA5 held. Read address 0. Expect readdata=32'h000000A5 one cycle after address is presented (after sync settles).
REQ-034 Setup EDGE_TYPE=0, mask=8'h01. Drive in_port[0] 0->1. Expect edge_capture=8'h01 and irq=1 exactly 4 clk later. Then write 32'h1 to address 3. Expect edge_capture=0 and irq=0 one clk after the clear.
REQ-035 Setup mask=0. Drive a rising edge on bit 3. Expect edge_capture=8'h08 and irq=0. Then write mask=8'h08. Expect irq=1 two clk later.
REQ-036 Setup BIT_CLEAR=1, edge_capture=8'h0C. Write 32'h04. Expect 8'h08. Repeat with BIT_CLEAR=0 and write 32'h0. Expect 8'h00.
REQ-037 Schedule a clear of bit 1 on the same clk as a new edge on bit 1. Expect edge_capture[1]=1 afterwards.
REQ-038 With edge_capture=8'hFF and mask=8'hFF, assert reset_n low asynchronously mid-cycle. Expect irq, readdata, mask and capture all 0 before the next clk edge.

Source files
------------

// File: rtl/nios_system_pio_in_irq_if.sv
// Avalon-MM slave bus for the PIO input block: word address, write strobe and
// registered read data.
interface nios_system_pio_in_irq_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios_system_pio_in_irq.sv
// PIO input port with synchronizer, edge capture register and maskable level
// interrupt, exposed as a 4-word Avalon-MM slave.
module nios_system_pio_in_irq #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TYPE   = 0,
    parameter int unsigned BIT_CLEAR   = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    nios_system_pio_in_irq_if.slave        avs,
    input  logic [WIDTH-1:0]               in_port,
    output logic                           irq
);

    localparam logic [1:0] AddrData    = 2'd0;
    localparam logic [1:0] AddrRsvd    = 2'd1;
    localparam logic [1:0] AddrMask    = 2'd2;
    localparam logic [1:0] AddrCapture = 2'd3;

    localparam int unsigned ChainW = SYNC_STAGES * WIDTH;

    // Stage 0 sits in the low WIDTH bits; the last stage is the top slice.
    logic [ChainW-1:0] chain_q, chain_d;
    logic [WIDTH-1:0]  sync;
    logic [WIDTH-1:0]  prev_q;
    logic [WIDTH-1:0]  edge_det;
    logic [WIDTH-1:0]  mask_q, mask_d;
    logic [WIDTH-1:0]  cap_q, cap_d;
    logic [WIDTH-1:0]  cap_clr;
    logic [WIDTH-1:0]  wdata;
    logic [31:0]       rdata_q, rdata_d;
    logic              irq_q, irq_d;
    logic              wr_en;

    assign chain_d = {chain_q[ChainW-WIDTH-1:0], in_port};
    assign sync    = chain_q[ChainW-1 -: WIDTH];

    assign wr_en = avs.chipselect & ~avs.write_n;
    assign wdata = avs.writedata[WIDTH-1:0];

    always_comb begin
        case (EDGE_TYPE)
            0:       edge_det = sync & ~prev_q;
            1:       edge_det = ~sync & prev_q;
            default: edge_det = sync ^ prev_q;
        endcase
    end

    always_comb begin
        mask_d  = mask_q;
        cap_clr = '0;
        if (wr_en && (avs.address == AddrMask)) begin
            mask_d = wdata;
        end
        if (wr_en && (avs.address == AddrCapture)) begin
            cap_clr = (BIT_CLEAR != 0) ? wdata : {WIDTH{1'b1}};
        end
        // A fresh edge overrides a clear landing on the same cycle.
        cap_d = (cap_q & ~cap_clr) | edge_det;
        irq_d = |(cap_q & mask_q);
    end

    always_comb begin
        rdata_d = '0;
        unique case (avs.address)
            AddrData:    rdata_d[WIDTH-1:0] = sync;
            AddrRsvd:    rdata_d = '0;
            AddrMask:    rdata_d[WIDTH-1:0] = mask_q;
            AddrCapture: rdata_d[WIDTH-1:0] = cap_q;
            default:     rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain_q <= '0;
            prev_q  <= '0;
            mask_q  <= '0;
            cap_q   <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            chain_q <= chain_d;
            prev_q  <= sync;
            mask_q  <= mask_d;
            cap_q   <= cap_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

    assign avs.readdata = rdata_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_nios_system_pio_in_irq.sv
// Bench for nios_system_pio_in_irq: two instances (rising/bit-clear and
// any-edge/clear-all) share stimulus; reads are checked by a scoreboard monitor.
module tb_nios_system_pio_in_irq;

    typedef struct packed {
        logic [31:0] d0;
        logic        i0;
        logic [31:0] d1;
        logic        i1;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic [7:0] in_port;
    logic       irq0;
    logic       irq1;
    logic       rd_req;
    logic       rd_vld;

    int n_checks;
    int n_errors;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  mon_e;
    string mon_nm;

    nios_system_pio_in_irq_if bus0 ();
    nios_system_pio_in_irq_if bus1 ();

    nios_system_pio_in_irq #(
        .WIDTH      (8),
        .SYNC_STAGES(2),
        .EDGE_TYPE  (0),
        .BIT_CLEAR  (1)
    ) dut0 (
        .clk    (clk),
        .reset_n(reset_n),
        .avs    (bus0),
        .in_port(in_port),
        .irq    (irq0)
    );

    nios_system_pio_in_irq #(
        .WIDTH      (8),
        .SYNC_STAGES(2),
        .EDGE_TYPE  (2),
        .BIT_CLEAR  (0)
    ) dut1 (
        .clk    (clk),
        .reset_n(reset_n),
        .avs    (bus1),
        .in_port(in_port),
        .irq    (irq1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rd_vld <= rd_req;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: read data appears one cycle after the address was presented.
    always @(negedge clk) begin
        if (rd_vld) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_nm = name_q.pop_front();
                check($sformatf("%s.rd0", mon_nm), bus0.readdata, mon_e.d0);
                check($sformatf("%s.irq0", mon_nm), {31'd0, irq0}, {31'd0, mon_e.i0});
                check($sformatf("%s.rd1", mon_nm), bus1.readdata, mon_e.d1);
                check($sformatf("%s.irq1", mon_nm), {31'd0, irq1}, {31'd0, mon_e.i1});
            end
        end
    end

    task automatic drive_bus(input logic [1:0] a, input logic cs, input logic wn,
                             input logic [31:0] d);
        bus0.address = a;  bus0.chipselect = cs;  bus0.write_n = wn;  bus0.writedata = d;
        bus1.address = a;  bus1.chipselect = cs;  bus1.write_n = wn;  bus1.writedata = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive_bus(2'd1, 1'b0, 1'b1, 32'd0);
            rd_req = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        drive_bus(a, 1'b1, 1'b0, d);
        rd_req = 1'b0;
        @(posedge clk);
        #1;
        drive_bus(2'd1, 1'b0, 1'b1, 32'd0);
    endtask

    // Reads leave chipselect low: read data is registered regardless.
    task automatic rd(input logic [1:0] a, input string nm, input logic [31:0] d0,
                      input logic i0, input logic [31:0] d1, input logic i1);
        exp_t e;
        e.d0 = d0;  e.i0 = i0;  e.d1 = d1;  e.i1 = i1;
        exp_q.push_back(e);
        name_q.push_back(nm);
        drive_bus(a, 1'b0, 1'b1, 32'd0);
        rd_req = 1'b1;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        drive_bus(2'd1, 1'b0, 1'b1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rd_req   = 1'b0;
        reset_n  = 1'b0;
        in_port  = 8'h00;
        drive_bus(2'd1, 1'b0, 1'b1, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        check("rst_rd0", bus0.readdata, 32'd0);
        check("rst_irq0", {31'd0, irq0}, 32'd0);
        check("rst_rd1", bus1.readdata, 32'd0);
        check("rst_irq1", {31'd0, irq1}, 32'd0);
        rd(2'd1, "rsv_rst", 32'h0, 1'b0, 32'h0, 1'b0);

        // Data path and capture of the initial pattern.
        in_port = 8'hA5;
        idle(3);
        rd(2'd0, "data_a5", 32'hA5, 1'b0, 32'hA5, 1'b0);
        rd(2'd3, "cap_a5", 32'hA5, 1'b0, 32'hA5, 1'b0);
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1, "rsv_wr", 32'h0, 1'b0, 32'h0, 1'b0);
        wr(2'd3, 32'hFF);
        rd(2'd3, "cap_clr", 32'h0, 1'b0, 32'h0, 1'b0);

        // Falling edge on bit 0: only the any-edge instance captures it.
        in_port = 8'hA4;
        idle(4);
        rd(2'd3, "any_fall", 32'h0, 1'b0, 32'h01, 1'b0);
        wr(2'd3, 32'h0);
        rd(2'd3, "bc0_wr0", 32'h0, 1'b0, 32'h0, 1'b0);
        wr(2'd2, 32'h1);
        idle(1);

        // Rising edge on bit 0 reaches irq SYNC_STAGES+2 clocks later.
        in_port = 8'hA5;
        idle(2);
        rd(2'd3, "lat3", 32'h0, 1'b0, 32'h0, 1'b0);
        rd(2'd3, "lat4", 32'h01, 1'b1, 32'h01, 1'b1);
        wr(2'd3, 32'h1);
        rd(2'd3, "clr_irq", 32'h0, 1'b0, 32'h0, 1'b0);

        // Capture is independent of the mask; unmasking raises irq.
        wr(2'd2, 32'h0);
        in_port = 8'hAD;
        idle(3);
        rd(2'd3, "mask0_cap", 32'h08, 1'b0, 32'h08, 1'b0);
        wr(2'd2, 32'hABCD_1208);
        rd(2'd2, "mask_set", 32'h08, 1'b1, 32'h08, 1'b1);

        // Build capture 0x0C, then per-bit versus clear-all behaviour.
        in_port = 8'hA9;
        idle(1);
        in_port = 8'hAD;
        idle(3);
        rd(2'd3, "cap_0c", 32'h0C, 1'b1, 32'h0C, 1'b1);
        wr(2'd3, 32'h04);
        rd(2'd3, "bitclr", 32'h08, 1'b1, 32'h00, 1'b0);

        // Clear of bit 1 lands on the same edge that sets it.
        in_port = 8'hAF;
        idle(2);
        wr(2'd3, 32'h02);
        rd(2'd3, "set_wins", 32'h0A, 1'b1, 32'h02, 1'b0);

        wr(2'd3, 32'hFF);
        in_port = 8'hAD;
        idle(3);
        rd(2'd3, "fall", 32'h00, 1'b0, 32'h02, 1'b0);

        // Fill capture and mask, then reset asynchronously mid-cycle.
        wr(2'd2, 32'hFF);
        in_port = 8'h00;
        idle(1);
        in_port = 8'hFF;
        idle(4);
        rd(2'd3, "cap_ff", 32'hFF, 1'b1, 32'hFF, 1'b1);
        rd(2'd2, "mask_ff", 32'hFF, 1'b1, 32'hFF, 1'b1);
        idle(1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_rd0", bus0.readdata, 32'd0);
        check("arst_irq0", {31'd0, irq0}, 32'd0);
        check("arst_rd1", bus1.readdata, 32'd0);
        check("arst_irq1", {31'd0, irq1}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // in_port held high through reset shows up as a rising edge.
        rd(2'd2, "rst_mask", 32'h0, 1'b0, 32'h0, 1'b0);
        rd(2'd3, "rst_cap", 32'h0, 1'b0, 32'h0, 1'b0);
        idle(1);
        rd(2'd3, "rel_rise", 32'hFF, 1'b0, 32'hFF, 1'b0);

        idle(2);
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
